// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg
// Shared constants, slot state type and the round-robin pick helper used by
// the four-requester arbiter (rr_arb4) and its payload steering mux.
package rr_arb4_pkg;

    // Default datapath width of the core.
    localparam int ARCH_WIDTH = 64;
    // Number of requesters and width of a requester index.
    localparam int ARB_NREQ   = 4;
    localparam int ARB_IDW    = 2;

    // After reset the "previous winner" is 3, so the search starts at 0.
    localparam logic [ARB_IDW-1:0] RESET_LAST_GRANT = 2'b11;

    // Output slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Result of one round-robin search.
    typedef struct packed {
        logic               any;
        logic [ARB_IDW-1:0] idx;
    } rr_pick_t;

    // Scan last+1, last+2, last+3, last+4 (mod 4); the first valid index wins.
    // Bits with valid=0 never influence the result.
    function automatic rr_pick_t rr_pick(input logic [ARB_IDW-1:0]  last,
                                         input logic [ARB_NREQ-1:0] valid);
        rr_pick_t           res;
        logic [ARB_IDW-1:0] cand;
        res.any = 1'b0;
        res.idx = 2'd0;
        for (int k = 1; k <= ARB_NREQ; k++) begin
            cand = last + 2'(k);
            if (!res.any && valid[cand]) begin
                res.any = 1'b1;
                res.idx = cand;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb4_mux4_1.sv
// mux4_1
// Purely combinational 4:1 payload select.
// Ports:
//   sel_i  2      select (0 -> a_i ... 3 -> d_i)
//   a_i..d_i      WIDTH payload inputs
//   y_o    WIDTH  selected payload
module mux4_1 #(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] y_o
);

    // Steer the selected input to the output.
    always_comb begin
        y_o = '0;
        case (sel_i)
            2'd0:    y_o = a_i;
            2'd1:    y_o = b_i;
            2'd2:    y_o = c_i;
            2'd3:    y_o = d_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4
// Four-requester round-robin arbiter with a single registered output slot.
// Each cycle the next requester after the previous winner is granted when the
// slot is empty or being drained; its payload is captured into the slot and
// presented downstream with a valid/ready handshake.
// Ports:
//   clk        in   1      core clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req_valid  in   4      per-requester valid, bit i = requester i
//   req_data0..3 in WIDTH  per-requester payload
//   req_ready  out  4      per-requester accept (one-hot or zero, combinational)
//   out_valid  out  1      slot holds a payload
//   out_data   out  WIDTH  granted payload
//   out_id     out  2      requester that owns out_data
//   out_ready  in   1      consumer accepts out_data this cycle
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int WIDTH = ARCH_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ARB_NREQ-1:0] req_valid,
    input  logic [WIDTH-1:0]    req_data0,
    input  logic [WIDTH-1:0]    req_data1,
    input  logic [WIDTH-1:0]    req_data2,
    input  logic [WIDTH-1:0]    req_data3,
    output logic [ARB_NREQ-1:0] req_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic [ARB_IDW-1:0]  out_id,
    input  logic                out_ready
);

    slot_state_e        state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [ARB_IDW-1:0] out_id_q, out_id_d;
    logic [ARB_IDW-1:0] last_grant_q, last_grant_d;

    rr_pick_t           pick_s;
    logic               can_accept_s;
    logic               grant_s;
    logic [WIDTH-1:0]   sel_data_s;
    logic [ARB_NREQ-1:0] req_ready_s;

    // Payload steering follows the combinational winner.
    mux4_1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (pick_s.idx),
        .a_i   (req_data0),
        .b_i   (req_data1),
        .c_i   (req_data2),
        .d_i   (req_data3),
        .y_o   (sel_data_s)
    );

    // Round-robin search and accept condition; depends only on valids,
    // slot occupancy and out_ready, never on the slot contents.
    always_comb begin
        pick_s       = rr_pick(last_grant_q, req_valid);
        can_accept_s = (state_q == SLOT_EMPTY) | out_ready;
        grant_s      = pick_s.any & can_accept_s;
    end

    // Slot next-state, capture and grant decode.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        last_grant_d = last_grant_q;
        req_ready_s  = 4'b0000;
        case (state_q)
            SLOT_EMPTY, SLOT_FULL: begin
                if (grant_s) begin
                    // New accept; also covers drain-and-refill in one cycle.
                    req_ready_s  = 4'b0001 << pick_s.idx;
                    state_d      = SLOT_FULL;
                    out_data_d   = sel_data_s;
                    out_id_d     = pick_s.idx;
                    last_grant_d = pick_s.idx;
                end else if ((state_q == SLOT_FULL) && out_ready) begin
                    // Drain with nothing to refill: data and id are kept.
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
    end

    // Slot and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SLOT_EMPTY;
            out_data_q   <= '0;
            out_id_q     <= 2'd0;
            last_grant_q <= RESET_LAST_GRANT;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_ready = req_ready_s;
    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4 with a transaction-level reference model.
module tb_rr_arb4;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [W-1:0] dat [4];
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_id;
    logic         out_ready;

    int checks;
    int errors;

    // Reference model: slot contents and the previous winner.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    int           m_last;

    rr_arb4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data0 (dat[0]),
        .req_data1 (dat[1]),
        .req_data2 (dat[2]),
        .req_data3 (dat[3]),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_last  = 3;
    endtask

    // One clock: apply inputs, check req_ready, clock, check slot outputs.
    task automatic cycle(input logic [3:0] v, input logic ob);
        int         win;
        bit         can;
        logic [3:0] exp_rdy;
        req_valid = v;
        out_ready = ob;
        #1;
        can = !m_valid || ob;
        win = -1;
        for (int k = 1; k <= 4; k++) begin
            if (win < 0 && v[(m_last + k) % 4]) win = (m_last + k) % 4;
        end
        exp_rdy = (win >= 0 && can) ? (4'b0001 << win) : 4'b0000;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready t=%0t got %b expected %b", $time, req_ready, exp_rdy);
        end
        @(posedge clk);
        if (win >= 0 && can) begin
            m_valid = 1'b1;
            m_data  = dat[win];
            m_id    = win;
            m_last  = win;
        end else if (m_valid && ob) begin
            m_valid = 1'b0;
        end
        #1;
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid t=%0t got %b expected %b", $time, out_valid, m_valid);
        end
        checks++;
        if (out_id !== 2'(m_id)) begin
            errors++;
            $display("FAIL out_id t=%0t got %0d expected %0d", $time, out_id, m_id);
        end
        checks++;
        if (out_data !== m_data) begin
            errors++;
            $display("FAIL out_data t=%0t got %h expected %h", $time, out_data, m_data);
        end
    endtask

    // Synchronous-looking reset pulse aligned to posedge+1.
    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        dat[0] = 64'h1111_0000_0000_0001;
        dat[1] = 64'h2222_0000_0000_0002;
        dat[2] = 64'h3333_0000_0000_0003;
        dat[3] = 64'h4444_0000_0000_0004;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b id=%0d d=%h expected 0/0/0", out_valid, out_id, out_data);
        end
        rst_n = 1'b1;
        cycle(4'b1111, 1'b1);
        checks++;
        if (out_id !== 2'd0 || out_data !== 64'h1111_0000_0000_0001) begin
            errors++;
            $display("FAIL first_grant got id=%0d d=%h expected 0 / 1111000000000001", out_id, out_data);
        end
    endtask

    task automatic test_rotate();
        apply_reset();
        dat[0] = 64'h10; dat[1] = 64'h20; dat[2] = 64'h30; dat[3] = 64'h40;
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b1111;
            out_ready = 1'b1;
            #1;
            checks++;
            if ($countones(req_ready) != 1) begin
                errors++;
                $display("FAIL rotate_onehot got %b expected one bit", req_ready);
            end
            cycle(4'b1111, 1'b1);
            checks++;
            if (out_id !== 2'(i % 4) || out_data !== 64'(16 * (i % 4 + 1))) begin
                errors++;
                $display("FAIL rotate_seq got id=%0d d=%h expected id=%0d", out_id, out_data, i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        apply_reset();
        dat[0] = 64'hA0; dat[1] = 64'hA1; dat[2] = 64'hA2; dat[3] = 64'hA3;
        cycle(4'b0010, 1'b1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b0);
            checks++;
            if (out_id !== 2'd1 || out_data !== 64'hA1 || held !== 64'hA1) begin
                errors++;
                $display("FAIL stall_hold got id=%0d d=%h expected 1 / a1", out_id, out_data);
            end
        end
        cycle(4'b1111, 1'b1);
        checks++;
        if (out_id !== 2'd2) begin
            errors++;
            $display("FAIL stall_release got id=%0d expected 2", out_id);
        end
    endtask

    task automatic test_single3();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            dat[3] = 64'(32'hC000 + i);
            cycle(4'b1000, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 64'(32'hC000 + i)) begin
                errors++;
                $display("FAIL single3 got v=%b id=%0d d=%h expected 1/3/%h", out_valid, out_id, out_data, 32'hC000 + i);
            end
        end
    endtask

    task automatic test_drain();
        apply_reset();
        dat[2] = 64'hDEAD_BEEF;
        cycle(4'b0100, 1'b1);
        dat[2] = 64'h0;
        cycle(4'b0000, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'hDEAD_BEEF || out_id !== 2'd2) begin
            errors++;
            $display("FAIL drain got v=%b d=%h id=%0d expected 0/deadbeef/2", out_valid, out_data, out_id);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        dat[0] = 64'h55; dat[1] = 64'h66; dat[2] = 64'h77; dat[3] = 64'h88;
        cycle(4'b0100, 1'b1);
        cycle(4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h expected 0/0", out_valid, out_data);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(4'b1001, 1'b1);
        checks++;
        if (out_id !== 2'd0 || out_data !== 64'h55) begin
            errors++;
            $display("FAIL post_reset_prio got id=%0d d=%h expected 0/55", out_id, out_data);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < 4; r++) dat[r] = {$urandom, $urandom};
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) dat[r] = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_rotate();
        test_backpressure();
        test_single3();
        test_drain();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
